mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 13, memory word-address width.
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles from o_mem_op=READ to valid i_mem_data; legal range 1..7.
REQ-004 SHALL have port i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_h_req  in  1 / i_h_op  in  2 / i_h_addr  in  ADDR_W / i_h_wdata  in  DATA_W: host request; op 0=NOP, 1=READ, 2=WRITE, 3=reserved.
REQ-007 SHALL have ports o_h_ack  out  1 / o_h_rdata  out  DATA_W / o_h_rvalid  out  1: host accept pulse, read data, read-data-valid pulse.
REQ-008 SHALL have ports i_c_req, i_c_op, i_c_addr, i_c_wdata, o_c_ack, o_c_rdata, o_c_rvalid: same widths and meanings for the ICP requester.
REQ-009 SHALL have ports o_mem_op  out  2 / o_mem_addr  out  ADDR_W / o_mem_data  out  DATA_W / i_mem_data  in  DATA_W: shared memory port.
REQ-010 SHALL have port o_busy  out  1  high whenever state is not IDLE.
REQ-011 SHALL have port o_owner  out  1  requester of the current or last transaction (0=host, 1=ICP).

Function
REQ-012 SHALL treat a requester as eligible in a cycle when req=1 and op is READ or WRITE; op NOP or 3 SHALL never be granted, acked, or forwarded.
REQ-013 SHALL sample requests only in IDLE; requesters hold req/op/addr/wdata stable until ack; a request withdrawn before ack is dropped silently.
REQ-014 SHALL arbitrate round-robin: single eligible requester wins; both eligible -> requester not equal to o_owner wins; o_owner is 1 after reset, so host wins the first tie.
REQ-015 SHALL implement FSM IDLE -> ISSUE -> (READ: WAIT -> RESP -> IDLE) / (WRITE: IDLE); unreachable encodings return to IDLE next cycle.
REQ-016 SHALL, on grant sampled at end of cycle N, in cycle N+1 (ISSUE) drive o_mem_op/o_mem_addr/o_mem_data from the winner, pulse winner ack for exactly that cycle, update o_owner.
REQ-017 SHALL drive o_mem_op=NOP in every cycle other than ISSUE; o_mem_addr and o_mem_data hold their last values.
REQ-018 SHALL, for READ, count READ_LATENCY cycles in WAIT, capture i_mem_data at end of cycle N+1+READ_LATENCY into winner rdata, assert winner rvalid for exactly cycle N+2+READ_LATENCY (RESP).
REQ-019 SHALL hold o_x_rdata until the next read for that requester completes; the other requester's rdata SHALL be unchanged.
REQ-020 SHALL return to IDLE in cycle N+2 after a WRITE and N+3+READ_LATENCY after a READ, able to grant in that cycle.
REQ-021 SHALL assert at most one ack, one rvalid, and one non-NOP o_mem_op per cycle, with at most one transaction outstanding.

Reset
REQ-022 SHALL, while i_rst_n=0, asynchronously force state IDLE, o_mem_op=NOP, o_mem_addr=0, o_mem_data=0, o_h_ack=o_c_ack=0, o_h_rvalid=o_c_rvalid=0, o_h_rdata=o_c_rdata=0, o_busy=0, o_owner=1.
REQ-023 SHALL, on reset during ISSUE/WAIT/RESP, abandon the transaction: no ack or rvalid after deassertion; first grant no earlier than the first rising edge after i_rst_n returns high.

Verification
REQ-024 SHALL pass: host WRITE addr 0x005 data 0xDEAD_BEEF alone -> one ISSUE cycle with o_mem_op=2, addr 0x005, o_h_ack single pulse, o_busy low two cycles later.
REQ-025 SHALL pass: host READ addr 0x005, memory returns 0xDEAD_BEEF, READ_LATENCY=1 -> o_h_rvalid one pulse at N+3 with o_h_rdata=0xDEAD_BEEF; o_c_rdata stays 0.
REQ-026 SHALL pass: host and ICP request READ same cycle after reset -> host served first, ICP ISSUE in the cycle after host RESP; next simultaneous pair -> host wins (owner=ICP).
REQ-027 SHALL pass: both continuously request WRITE for 8 transactions -> grants alternate H,C,H,C...; exactly 4 acks each.
REQ-028 SHALL pass: i_rst_n low during WAIT of ICP read -> all outputs at reset values immediately, no o_c_rvalid ever for that read.
REQ-029 SHALL pass: ICP op=3 or NOP with req=1 -> no ack, o_mem_op stays NOP, o_busy stays 0; concurrent host WRITE granted normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the host, ICP and shared-memory signals of mem_arbiter.
// The arbiter uses the slave view; a requester/memory model uses the master view.
interface mem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13
);
  logic              i_h_req;
  logic [1:0]        i_h_op;
  logic [ADDR_W-1:0] i_h_addr;
  logic [DATA_W-1:0] i_h_wdata;
  logic              o_h_ack;
  logic [DATA_W-1:0] o_h_rdata;
  logic              o_h_rvalid;

  logic              i_c_req;
  logic [1:0]        i_c_op;
  logic [ADDR_W-1:0] i_c_addr;
  logic [DATA_W-1:0] i_c_wdata;
  logic              o_c_ack;
  logic [DATA_W-1:0] o_c_rdata;
  logic              o_c_rvalid;

  logic [1:0]        o_mem_op;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_data;
  logic [DATA_W-1:0] i_mem_data;

  logic              o_busy;
  logic              o_owner;

  modport slave (
    input  i_h_req, i_h_op, i_h_addr, i_h_wdata,
    output o_h_ack, o_h_rdata, o_h_rvalid,
    input  i_c_req, i_c_op, i_c_addr, i_c_wdata,
    output o_c_ack, o_c_rdata, o_c_rvalid,
    output o_mem_op, o_mem_addr, o_mem_data,
    input  i_mem_data,
    output o_busy, o_owner
  );

  modport master (
    output i_h_req, i_h_op, i_h_addr, i_h_wdata,
    input  o_h_ack, o_h_rdata, o_h_rvalid,
    output i_c_req, i_c_op, i_c_addr, i_c_wdata,
    input  o_c_ack, o_c_rdata, o_c_rvalid,
    input  o_mem_op, o_mem_addr, o_mem_data,
    output i_mem_data,
    input  o_busy, o_owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a host and an ICP requester.
// One transaction in flight at a time; every output is driven from a register.
module mem_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 13,
  parameter int READ_LATENCY = 1
) (
  input logic          i_clk,
  input logic          i_rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              w_h_elig;
  logic              w_c_elig;
  logic              w_grant;
  logic              w_grant_c;
  logic [1:0]        w_win_op;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;

  logic [1:0]        r_mem_op;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_h_ack;
  logic              r_c_ack;
  logic              r_h_rvalid;
  logic              r_c_rvalid;
  logic [DATA_W-1:0] r_h_rdata;
  logic [DATA_W-1:0] r_c_rdata;
  logic              r_busy;
  logic              r_owner;
  logic              r_is_read;
  logic [2:0]        r_wait_cnt;

  // Eligibility and round-robin winner selection; a tie goes to the non-owner.
  always_comb begin
    w_h_elig = bus.i_h_req && ((bus.i_h_op == OP_READ) || (bus.i_h_op == OP_WRITE));
    w_c_elig = bus.i_c_req && ((bus.i_c_op == OP_READ) || (bus.i_c_op == OP_WRITE));
    w_grant  = (r_state == S_IDLE) && (w_h_elig || w_c_elig);
    if (w_h_elig && w_c_elig) begin
      w_grant_c = ~r_owner;
    end else begin
      w_grant_c = w_c_elig;
    end
    if (w_grant_c) begin
      w_win_op   = bus.i_c_op;
      w_win_addr = bus.i_c_addr;
      w_win_data = bus.i_c_wdata;
    end else begin
      w_win_op   = bus.i_h_op;
      w_win_addr = bus.i_h_addr;
      w_win_data = bus.i_h_wdata;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_is_read) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs: ack/mem_op/rvalid are one-cycle pulses, the rest hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_op   <= OP_NOP;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_h_ack    <= 1'b0;
      r_c_ack    <= 1'b0;
      r_h_rvalid <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_h_rdata  <= '0;
      r_c_rdata  <= '0;
      r_busy     <= 1'b0;
      r_owner    <= 1'b1;
      r_is_read  <= 1'b0;
      r_wait_cnt <= 3'd0;
    end else begin
      r_mem_op   <= OP_NOP;
      r_h_ack    <= 1'b0;
      r_c_ack    <= 1'b0;
      r_h_rvalid <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_busy     <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_mem_op   <= w_win_op;
            r_mem_addr <= w_win_addr;
            r_mem_data <= w_win_data;
            r_owner    <= w_grant_c;
            r_h_ack    <= ~w_grant_c;
            r_c_ack    <= w_grant_c;
            r_is_read  <= (w_win_op == OP_READ);
            r_wait_cnt <= LAT_LAST;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 3'd0) begin
            // The owner register still names the requester of this read.
            if (r_owner) begin
              r_c_rdata  <= bus.i_mem_data;
              r_c_rvalid <= 1'b1;
            end else begin
              r_h_rdata  <= bus.i_mem_data;
              r_h_rvalid <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        default: begin
          r_is_read <= r_is_read;
        end
      endcase
    end
  end

  assign bus.o_mem_op   = r_mem_op;
  assign bus.o_mem_addr = r_mem_addr;
  assign bus.o_mem_data = r_mem_data;
  assign bus.o_h_ack    = r_h_ack;
  assign bus.o_c_ack    = r_c_ack;
  assign bus.o_h_rvalid = r_h_rvalid;
  assign bus.o_c_rvalid = r_c_rvalid;
  assign bus.o_h_rdata  = r_h_rdata;
  assign bus.o_c_rdata  = r_c_rdata;
  assign bus.o_busy     = r_busy;
  assign bus.o_owner    = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-timeline reference model.
module tb_mem_arbiter;
  localparam int DW = 64;
  localparam int AW = 13;
  localparam int RL = 1;
  localparam int NC = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Timeline of predicted events, indexed by cycle.
  bit          ev_iss  [NC];
  bit          ev_iss_c[NC];
  logic [1:0]  ev_op   [NC];
  logic [AW-1:0] ev_addr[NC];
  logic [DW-1:0] ev_data[NC];
  bit          ev_rv   [NC];
  bit          ev_rv_c [NC];
  logic [DW-1:0] hist  [NC];

  logic          m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_mdata, m_hrd, m_crd;
  int            m_free;

  logic          h_req, c_req;
  logic [1:0]    h_op, c_op;
  logic [AW-1:0] h_addr, c_addr;
  logic [DW-1:0] h_wdata, c_wdata;
  int            h_life, c_life;

  bit rnd_mode = 1'b0;
  bit refill   = 1'b0;
  bit mem_fix  = 1'b0;
  logic [DW-1:0] mem_fix_val = '0;
  int cnt_h_ack, cnt_c_ack, cnt_c_rv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_op", 64'(bus.o_mem_op), 64'd0);
    chk("rst_mem_addr", 64'(bus.o_mem_addr), 64'd0);
    chk("rst_mem_data", 64'(bus.o_mem_data), 64'd0);
    chk("rst_h_ack", 64'(bus.o_h_ack), 64'd0);
    chk("rst_c_ack", 64'(bus.o_c_ack), 64'd0);
    chk("rst_h_rvalid", 64'(bus.o_h_rvalid), 64'd0);
    chk("rst_c_rvalid", 64'(bus.o_c_rvalid), 64'd0);
    chk("rst_h_rdata", 64'(bus.o_h_rdata), 64'd0);
    chk("rst_c_rdata", 64'(bus.o_c_rdata), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_owner", 64'(bus.o_owner), 64'd1);
  endtask

  task automatic model_reset();
    m_owner = 1'b1; m_addr = '0; m_mdata = '0; m_hrd = '0; m_crd = '0; m_free = 0;
    for (int k = cyc; k < NC && k < cyc + 16; k++) begin
      ev_iss[k] = 1'b0; ev_rv[k] = 1'b0;
    end
    h_req = 1'b0; c_req = 1'b0; h_op = 2'd0; c_op = 2'd0;
  endtask

  task automatic drive();
    bus.i_h_req = h_req; bus.i_h_op = h_op; bus.i_h_addr = h_addr; bus.i_h_wdata = h_wdata;
    bus.i_c_req = c_req; bus.i_c_op = c_op; bus.i_c_addr = c_addr; bus.i_c_wdata = c_wdata;
  endtask

  task automatic step(input bit do_rst);
    bit e_ack_h, e_ack_c, e_rv_h, e_rv_c, he, ce, who;
    logic [1:0] e_op;
    @(posedge clk);
    cyc++;
    #1;
    e_ack_h = 1'b0; e_ack_c = 1'b0; e_rv_h = 1'b0; e_rv_c = 1'b0; e_op = 2'd0;
    if (ev_iss[cyc]) begin
      e_op = ev_op[cyc]; m_addr = ev_addr[cyc]; m_mdata = ev_data[cyc];
      m_owner = ev_iss_c[cyc];
      if (ev_iss_c[cyc]) e_ack_c = 1'b1; else e_ack_h = 1'b1;
    end
    if (ev_rv[cyc]) begin
      if (ev_rv_c[cyc]) begin e_rv_c = 1'b1; m_crd = hist[cyc-1]; end
      else begin e_rv_h = 1'b1; m_hrd = hist[cyc-1]; end
    end
    chk("mem_op", 64'(bus.o_mem_op), 64'(e_op));
    chk("mem_addr", 64'(bus.o_mem_addr), 64'(m_addr));
    chk("mem_data", 64'(bus.o_mem_data), 64'(m_mdata));
    chk("h_ack", 64'(bus.o_h_ack), 64'(e_ack_h));
    chk("c_ack", 64'(bus.o_c_ack), 64'(e_ack_c));
    chk("h_rvalid", 64'(bus.o_h_rvalid), 64'(e_rv_h));
    chk("c_rvalid", 64'(bus.o_c_rvalid), 64'(e_rv_c));
    chk("h_rdata", 64'(bus.o_h_rdata), 64'(m_hrd));
    chk("c_rdata", 64'(bus.o_c_rdata), 64'(m_crd));
    chk("busy", 64'(bus.o_busy), 64'(cyc < m_free));
    chk("owner", 64'(bus.o_owner), 64'(m_owner));
    cnt_h_ack += int'(bus.o_h_ack);
    cnt_c_ack += int'(bus.o_c_ack);
    cnt_c_rv  += int'(bus.o_c_rvalid);

    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      if (e_ack_h) begin
        h_req = 1'b0;
        if (refill) begin
          h_req = 1'b1; h_op = 2'd2; h_addr = AW'($urandom); h_wdata = {$urandom, $urandom};
        end
      end
      if (e_ack_c) begin
        c_req = 1'b0;
        if (refill) begin
          c_req = 1'b1; c_op = 2'd2; c_addr = AW'($urandom); c_wdata = {$urandom, $urandom};
        end
      end
      if (rnd_mode) begin
        if (h_req) begin
          h_life--;
          if (h_life <= 0) h_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          h_req = 1'b1; h_op = 2'($urandom_range(0, 3)); h_addr = AW'($urandom);
          h_wdata = {$urandom, $urandom}; h_life = $urandom_range(1, 12);
        end
        if (c_req) begin
          c_life--;
          if (c_life <= 0) c_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          c_req = 1'b1; c_op = 2'($urandom_range(0, 3)); c_addr = AW'($urandom);
          c_wdata = {$urandom, $urandom}; c_life = $urandom_range(1, 12);
        end
      end
    end

    hist[cyc] = mem_fix ? mem_fix_val : {$urandom, $urandom};
    bus.i_mem_data = hist[cyc];
    drive();

    // Grant decision for this cycle, from the arbitration rules and timeline.
    he = h_req && (h_op == 2'd1 || h_op == 2'd2);
    ce = c_req && (c_op == 2'd1 || c_op == 2'd2);
    if (!do_rst && cyc >= m_free && (he || ce) && cyc + RL + 4 < NC) begin
      who = (he && ce) ? ~m_owner : ce;
      ev_iss[cyc+1]   = 1'b1;
      ev_iss_c[cyc+1] = who;
      ev_op[cyc+1]    = who ? c_op : h_op;
      ev_addr[cyc+1]  = who ? c_addr : h_addr;
      ev_data[cyc+1]  = who ? c_wdata : h_wdata;
      if ((who ? c_op : h_op) == 2'd1) begin
        ev_rv[cyc+2+RL]   = 1'b1;
        ev_rv_c[cyc+2+RL] = who;
        m_free = cyc + 3 + RL;
      end else begin
        m_free = cyc + 2;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    h_req = 1'b0; c_req = 1'b0; h_op = 2'd0; c_op = 2'd0;
    h_addr = '0; c_addr = '0; h_wdata = '0; c_wdata = '0;
    h_life = 0; c_life = 0;
    cnt_h_ack = 0; cnt_c_ack = 0; cnt_c_rv = 0;
    for (int k = 0; k < NC; k++) begin
      ev_iss[k] = 1'b0; ev_rv[k] = 1'b0; hist[k] = '0;
    end
    bus.i_mem_data = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Lone host write to 0x005.
    h_req = 1'b1; h_op = 2'd2; h_addr = 13'h005; h_wdata = 64'hDEAD_BEEF;
    repeat (4) step(1'b0);

    // Lone host read with a fixed memory value; ICP rdata must stay zero.
    mem_fix = 1'b1; mem_fix_val = 64'hDEAD_BEEF;
    h_req = 1'b1; h_op = 2'd1; h_addr = 13'h005;
    repeat (6) step(1'b0);
    chk("h_rdata_read", 64'(bus.o_h_rdata), 64'hDEAD_BEEF);
    chk("c_rdata_zero", 64'(bus.o_c_rdata), 64'd0);
    mem_fix = 1'b0;

    // Simultaneous reads after reset, twice.
    step(1'b1);
    for (int p = 0; p < 2; p++) begin
      h_req = 1'b1; h_op = 2'd1; h_addr = AW'($urandom); c_req = 1'b1; c_op = 2'd1; c_addr = AW'($urandom);
      repeat (12) step(1'b0);
    end

    // Continuous writes from both sides: 8 transactions, 4 acks each.
    cnt_h_ack = 0; cnt_c_ack = 0; refill = 1'b1;
    h_req = 1'b1; h_op = 2'd2; c_req = 1'b1; c_op = 2'd2;
    repeat (16) step(1'b0);
    refill = 1'b0; h_req = 1'b0; c_req = 1'b0;
    chk("h_ack_count", 64'(cnt_h_ack), 64'd4);
    chk("c_ack_count", 64'(cnt_c_ack), 64'd4);
    repeat (3) step(1'b0);

    // Reset in the WAIT cycle of an ICP read: that read never returns.
    c_req = 1'b1; c_op = 2'd1; c_addr = 13'h1AB;
    step(1'b0);
    step(1'b0);
    cnt_c_rv = 0;
    step(1'b1);
    repeat (6) step(1'b0);
    chk("c_rvalid_abandoned", 64'(cnt_c_rv), 64'd0);

    // Ineligible ICP ops alongside a host write.
    c_req = 1'b1; c_op = 2'd3; c_addr = 13'h0FF;
    repeat (3) step(1'b0);
    h_req = 1'b1; h_op = 2'd2; h_addr = 13'h123; h_wdata = 64'h0123_4567_89AB_CDEF;
    repeat (4) step(1'b0);
    c_op = 2'd0;
    repeat (3) step(1'b0);
    c_req = 1'b0;

    // Random traffic with occasional resets.
    rnd_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0);
    end
    rnd_mode = 1'b0; h_req = 1'b0; c_req = 1'b0;
    repeat (10) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
